// File: rtl/alu_result_stage.sv
// ALU writeback stage: 2-entry in-order result buffer feeding the register-file
// write port, with retired-op status flags, a retire counter and a sticky flag error.
module alu_result_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              z_in,
    input  logic              a_grt_b_in,
    input  logic              b_grt_a_in,
    input  logic [REG_AW-1:0] dest_reg,
    input  logic              wb_en_in,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [REG_AW-1:0] wb_addr,
    output logic [2:0]        status_flags,
    output logic [CNT_W-1:0]  retire_count,
    output logic              flag_err,
    input  logic              err_clr
);

    logic [DATA_W-1:0] data_q [2];
    logic [2:0]        flg_q  [2];
    logic [REG_AW-1:0] dest_q [2];
    logic [1:0]        wben_q;

    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic [2:0]        status_q, status_d;
    logic [CNT_W-1:0]  retire_q, retire_d;
    logic              err_q, err_d;

    logic              push_s;
    logic              pop_s;
    logic              head_wben_s;
    logic              not_empty_s;

    // Handshake decode and head-entry presentation; in_ready only sees registered count.
    always_comb begin
        not_empty_s = (count_q != 2'd0);
        head_wben_s = wben_q[rd_ptr_q];
        in_ready    = (count_q < 2'd2);
        push_s      = in_valid & in_ready;
        pop_s       = not_empty_s & (~head_wben_s | wb_ready);
        wb_valid    = not_empty_s & head_wben_s;
        wb_data     = data_q[rd_ptr_q];
        wb_addr     = dest_q[rd_ptr_q];
    end

    // Next-state for pointers, occupancy, status, counter and error flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        status_d = status_q;
        retire_d = retire_q;
        err_d    = err_q;

        if (push_s) begin
            wr_ptr_d = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
            status_d = flg_q[rd_ptr_q];
            retire_d = retire_q + CNT_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // A new error on this push outranks a same-cycle clear.
        if (push_s & a_grt_b_in & b_grt_a_in) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Control and architectural state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            status_q <= 3'b000;
            retire_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            status_q <= status_d;
            retire_q <= retire_d;
            err_q    <= err_d;
        end
    end

    // Buffer storage; cleared on reset so the head outputs are never X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                flg_q[i]  <= 3'b000;
                dest_q[i] <= '0;
            end
            wben_q <= 2'b00;
        end else if (push_s) begin
            data_q[wr_ptr_q] <= alu_result;
            flg_q[wr_ptr_q]  <= {z_in, a_grt_b_in, b_grt_a_in};
            dest_q[wr_ptr_q] <= dest_reg;
            wben_q[wr_ptr_q] <= wb_en_in;
        end
    end

    assign status_flags = status_q;
    assign retire_count = retire_q;
    assign flag_err     = err_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: queue-based reference model checked every
// cycle, plus hand-computed expectations at key points of each scenario.
module tb_alu_result_stage;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] alu_result = '0;
    logic          z_in = 1'b0, a_grt_b_in = 1'b0, b_grt_a_in = 1'b0;
    logic [AW-1:0] dest_reg = '0;
    logic          wb_en_in = 1'b0;
    logic          wb_valid;
    logic          wb_ready = 1'b0;
    logic [DW-1:0] wb_data;
    logic [AW-1:0] wb_addr;
    logic [2:0]    status_flags;
    logic [CW-1:0] retire_count;
    logic          flag_err;
    logic          err_clr = 1'b0;

    int checks = 0;
    int failures = 0;

    alu_result_stage #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .z_in(z_in), .a_grt_b_in(a_grt_b_in),
        .b_grt_a_in(b_grt_a_in), .dest_reg(dest_reg), .wb_en_in(wb_en_in),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_addr(wb_addr), .status_flags(status_flags),
        .retire_count(retire_count), .flag_err(flag_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic [2:0]    flags;
        logic [AW-1:0] dest;
        logic          wb_en;
    } op_t;

    op_t        mq[$];
    logic [2:0] m_flags = 3'b000;
    int         m_cnt = 0;
    logic       m_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: compare at the falling edge, then apply the transition the
    // next rising edge will perform with the inputs currently being driven.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mq.delete();
                m_flags = 3'b000;
                m_cnt = 0;
                m_err = 1'b0;
            end
            chk("m_in_ready", 32'(in_ready), 32'(mq.size() < 2));
            chk("m_wb_valid", 32'(wb_valid), 32'(mq.size() > 0 && mq[0].wb_en));
            if (mq.size() > 0 && mq[0].wb_en) begin
                chk("m_wb_data", 32'(wb_data), 32'(mq[0].d));
                chk("m_wb_addr", 32'(wb_addr), 32'(mq[0].dest));
            end else begin
                chk("m_wb_known", 32'($isunknown({wb_data, wb_addr})), 32'd0);
            end
            chk("m_status", 32'(status_flags), 32'(m_flags));
            chk("m_retire", 32'(retire_count), 32'(m_cnt % 16));
            chk("m_flag_err", 32'(flag_err), 32'(m_err));
            if (rst_n) begin
                bit pu, po;
                op_t o;
                pu = in_valid && (mq.size() < 2);
                po = (mq.size() > 0) && (!mq[0].wb_en || wb_ready);
                if (po) begin
                    m_flags = mq[0].flags;
                    m_cnt = (m_cnt + 1) % 16;
                    void'(mq.pop_front());
                end
                if (pu) begin
                    o.d = alu_result;
                    o.flags = {z_in, a_grt_b_in, b_grt_a_in};
                    o.dest = dest_reg;
                    o.wb_en = wb_en_in;
                    mq.push_back(o);
                end
                if (pu && a_grt_b_in && b_grt_a_in) m_err = 1'b1;
                else if (err_clr) m_err = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [DW-1:0] d, input logic z, input logic ag,
                         input logic bg, input logic [AW-1:0] dst, input logic we);
        in_valid = 1'b1;
        alu_result = d;
        z_in = z;
        a_grt_b_in = ag;
        b_grt_a_in = bg;
        dest_reg = dst;
        wb_en_in = we;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        z_in = 1'b0;
        a_grt_b_in = 1'b0;
        b_grt_a_in = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", 32'(wb_data), 32'd0);
        chk("rst_retire", 32'(retire_count), 32'd0);
        rst_n = 1'b1;

        // Single writeback with minimum latency.
        wb_ready = 1'b1;
        drive(16'h1234, 1'b0, 1'b0, 1'b0, 3'd5, 1'b1);
        tick();
        idle();
        chk("single_valid", 32'(wb_valid), 32'd1);
        chk("single_data", 32'(wb_data), 32'h1234);
        chk("single_addr", 32'(wb_addr), 32'd5);
        tick();
        chk("single_retire", 32'(retire_count), 32'd1);
        chk("single_empty", 32'(wb_valid), 32'd0);

        // Backpressure: buffer fills, third op ignored, drain in order.
        wb_ready = 1'b0;
        drive(16'hAAAA, 1'b0, 1'b1, 1'b0, 3'd1, 1'b1);
        tick();
        drive(16'h5555, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1);
        tick();
        chk("bp_full", 32'(in_ready), 32'd0);
        drive(16'h0BAD, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1);
        tick();
        idle();
        chk("bp_hold_data", 32'(wb_data), 32'hAAAA);
        chk("bp_still_full", 32'(in_ready), 32'd0);
        wb_ready = 1'b1;
        tick();
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        chk("bp_second_data", 32'(wb_data), 32'h5555);
        tick();
        chk("bp_retire", 32'(retire_count), 32'd3);
        chk("bp_drained", 32'(wb_valid), 32'd0);

        // Flags-only op followed by a writeback op.
        wb_ready = 1'b0;
        drive(16'h0F0F, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0);
        tick();
        chk("fo_no_valid", 32'(wb_valid), 32'd0);
        drive(16'h7777, 1'b0, 1'b0, 1'b0, 3'd6, 1'b1);
        tick();
        idle();
        chk("fo_status", 32'(status_flags), 32'b100);
        chk("fo_next_valid", 32'(wb_valid), 32'd1);
        chk("fo_next_data", 32'(wb_data), 32'h7777);
        wb_ready = 1'b1;
        tick();
        chk("fo_retire", 32'(retire_count), 32'd5);

        // Flag error sets, persists, clears; set beats a coincident clear.
        drive(16'h0001, 1'b0, 1'b1, 1'b1, 3'd7, 1'b1);
        tick();
        idle();
        chk("err_set", 32'(flag_err), 32'd1);
        tick();
        chk("err_persist", 32'(flag_err), 32'd1);
        chk("err_op_retired", 32'(retire_count), 32'd6);
        chk("err_status", 32'(status_flags), 32'b011);
        err_clr = 1'b1;
        tick();
        chk("err_cleared", 32'(flag_err), 32'd0);
        drive(16'h0002, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1);
        tick();
        idle();
        chk("err_set_wins", 32'(flag_err), 32'd1);
        tick();
        err_clr = 1'b0;
        chk("err_cleared2", 32'(flag_err), 32'd0);

        // Asynchronous reset with two entries buffered.
        wb_ready = 1'b0;
        drive(16'hBEEF, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1);
        tick();
        drive(16'hCAFE, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1);
        tick();
        idle();
        chk("pre_rst_full", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_wb_valid", 32'(wb_valid), 32'd0);
        chk("arst_wb_data", 32'(wb_data), 32'd0);
        chk("arst_wb_addr", 32'(wb_addr), 32'd0);
        chk("arst_status", 32'(status_flags), 32'd0);
        chk("arst_retire", 32'(retire_count), 32'd0);
        chk("arst_flag_err", 32'(flag_err), 32'd0);
        tick();
        rst_n = 1'b1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk("rel_wb_valid", 32'(wb_valid), 32'd0);
        chk("rel_retire", 32'(retire_count), 32'd0);

        // Counter wrap: 17 back-to-back retirements with a 4-bit counter.
        wb_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(16'(16'h0100 + i), 1'b0, 1'b0, 1'b0, 3'(i), 1'b1);
            tick();
            chk("wrap_in_ready", 32'(in_ready), 32'd1);
            chk("wrap_rate", 32'(retire_count), 32'(i % 16));
        end
        idle();
        chk("wrap_after16", 32'(retire_count), 32'd0);
        tick();
        chk("wrap_after17", 32'(retire_count), 32'd1);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Writeback stage directly downstream of the 16-bit ALU. Captures each ALU result with its flags (zero, a>b, b>a) and destination register index into a 2-entry in-order buffer, and presents results to the register-file write port over a valid/ready handshake. It also keeps an architectural status-flag register, a retired-operation counter and a sticky flag-consistency error.

## Interface
- `DATA_W`, default 16, datapath width; matches the ALU result width.
- `REG_AW`, default 3, register-file address width (8 registers).
- `CNT_W`, default 16, retired-operation counter width.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  ALU output holds a valid operation this cycle.
- `in_ready`  out  1  the stage can accept an operation.
- `alu_result`  in  DATA_W  ALU `data_out`.
- `z_in`  in  1  ALU zero flag.
- `a_grt_b_in`  in  1  ALU a>b flag.
- `b_grt_a_in`  in  1  ALU b>a flag.
- `dest_reg`  in  REG_AW  destination register index.
- `wb_en_in`  in  1  1 means the result is written back; 0 means flags only (compare-type op).
- `wb_valid`  out  1  a writeback is offered.
- `wb_ready`  in  1  the register file accepts the writeback.
- `wb_data`  out  DATA_W  writeback data.
- `wb_addr`  out  REG_AW  writeback register index.
- `status_flags`  out  3  {z, a_grt_b, b_grt_a} of the most recently retired operation.
- `retire_count`  out  CNT_W  number of retired operations, modulo 2^CNT_W.
- `flag_err`  out  1  sticky error: an accepted op had a_grt_b_in = b_grt_a_in = 1.
- `err_clr`  in  1  synchronous clear of `flag_err`.

## Operation
- **Storage.** 2-entry FIFO: write pointer, read pointer and a 2-bit occupancy count. Each entry holds {result, z, agtb, bgta, dest, wb_en}.
- **Accept.** `push = in_valid & in_ready`. `in_ready = (count < 2)`. `in_ready` depends only on registered state; there is no combinational path from `wb_ready` or `in_valid`.
- **Head offer.**
  - `wb_valid = (count != 0) & head.wb_en`.
  - `wb_data` and `wb_addr` always show the head entry's fields.
  - When `wb_valid` is 0, `wb_data` and `wb_addr` are don't-care but must be stable and not X after reset.
- **Retire.** `pop = (count != 0) & (~head.wb_en | wb_ready)`.
  - Flags-only entries retire one cycle after becoming head, without `wb_valid` ever asserting.
- **On pop:**
  - `status_flags` <= head {z, agtb, bgta}.
  - `retire_count` increments and wraps from all-ones to 0.
- **Simultaneous push and pop.** Legal whenever `count` is 1. The count is unchanged and both pointers advance. With `count` = 2, `in_ready` is 0, so no push occurs even if a pop happens that cycle.
- **Ordering.** Strictly in order. Flags-only entries never overtake, or get overtaken by, writeback entries.
- **Flag error.** `flag_err` sets on a push where `a_grt_b_in & b_grt_a_in`. The operation is still stored and retired normally. If `err_clr` and a setting event coincide, the set wins.
- **Handshake stability.** Once `wb_valid` is 1 it stays 1, with stable `wb_data`/`wb_addr`, until the cycle `wb_ready` is 1.

## Timing
- **Reset.** Asynchronous assertion of `rst_n` = 0 immediately forces:
  - count 0, pointers 0;
  - `wb_valid` 0, `in_ready` 1;
  - `wb_data` 0, `wb_addr` 0;
  - `status_flags` 3'b000, `retire_count` 0, `flag_err` 0.
- **Reset deassertion.** Synchronous to `clk`. The first push is accepted on the first rising edge with `rst_n` = 1.
- **Reset mid-operation.** Buffered entries are discarded. No writeback is completed for them and the counter does not increment.
- **Latency.** An op pushed at edge N appears at the head after edge N if the buffer was empty.
  - It can retire at edge N+1, so the minimum latency is 1 cycle.
  - `status_flags` and `retire_count` update at the retiring edge.
- **Throughput.** 1 op/cycle sustained while `wb_ready` is held at 1.

## Test plan
- **Reset values.** Assert `rst_n` = 0 mid-stream with 2 entries buffered. Required: outputs go to reset values without waiting for a clock edge. After release, `in_ready` = 1, `wb_valid` = 0, `retire_count` = 0.
- **Single writeback.** Push result 0x1234, dest 5, wb_en 1, flags 000, with `wb_ready` = 1. Required: next cycle `wb_valid` = 1, `wb_data` = 0x1234, `wb_addr` = 5; it retires on that edge and `retire_count` = 1.
- **Backpressure.** Hold `wb_ready` = 0 and push 0xAAAA then 0x5555. Required: `in_ready` = 0 after the second push and a third `in_valid` is ignored. Release `wb_ready` and require 0xAAAA then 0x5555 in order, with `in_ready` returning to 1 after the first pop.
- **Flags-only op.** Push a wb_en = 0 op with z = 1, agtb = 0, bgta = 0, followed by a writeback op. Required: `wb_valid` never asserts for the first op, `status_flags` = 3'b100 after one cycle, then the second op is offered.
- **Flag error.** Push an op with `a_grt_b_in` = `b_grt_a_in` = 1. Required: `flag_err` = 1 and it persists; the op still retires. Then assert `err_clr` on a cycle with no new error. Required: `flag_err` = 0 next cycle.
- **Counter wrap.** Configure `CNT_W` = 4 and retire 17 ops back-to-back with `wb_ready` = 1. Required: one op per cycle, and `retire_count` reads 0 after the 16th op and 1 after the 17th.
